// File: rtl/div_seq_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_seq_ctrl_if : start/busy/done handshake and operand/result bus       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface div_seq_ctrl_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] deci;

  modport master (
    output start, a, b,
    input  busy, done, div_by_zero, q, deci
  );

  modport slave (
    input  start, a, b,
    output busy, done, div_by_zero, q, deci
  );
endinterface
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_seq_ctrl : sequential unsigned divider, quotient + decimal fraction  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module div_seq_ctrl #(
  parameter int WIDTH       = 16,
  parameter int FRAC_DIGITS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  div_seq_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int DIG_W = (FRAC_DIGITS > 1) ? $clog2(FRAC_DIGITS) : 1;
  localparam int RW    = WIDTH + 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_QUO  = 2'd1;
  localparam logic [1:0] S_FRAC = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [RW-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       step_q, step_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic [3:0]       digit_q, digit_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] deci_q, deci_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   quo_shift;
  logic [RW-1:0]    rem_x10;
  logic [RW-1:0]    frac_src;
  logic [1:0]       bit_pos;
  logic [RW-1:0]    sub_lhs;
  logic [RW-1:0]    sub_rhs;
  logic [RW:0]      sub_diff;
  logic             sub_ge;
  logic [RW-1:0]    sub_res;
  logic [3:0]       digit_fin;

  // One subtract/compare unit serves both the quotient and fraction phases.
  always_comb begin
    quo_shift = {rem_q[WIDTH-1:0], a_q[cnt_q]};
    rem_x10   = (rem_q << 3) + (rem_q << 1);
    frac_src  = (step_q == 2'd0) ? rem_x10 : rem_q;
    bit_pos   = 2'd3 - step_q;
    if (state_q == S_QUO) begin
      sub_lhs = RW'(quo_shift);
      sub_rhs = RW'(b_q);
    end else begin
      sub_lhs = frac_src;
      sub_rhs = RW'(b_q) << bit_pos;
    end
    sub_diff  = {1'b0, sub_lhs} - {1'b0, sub_rhs};
    sub_ge    = ~sub_diff[RW];
    sub_res   = sub_ge ? sub_diff[RW-1:0] : sub_lhs;
    digit_fin = digit_q | {3'b000, sub_ge};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    dig_d   = dig_q;
    digit_d = digit_q;
    q_d     = q_q;
    deci_d  = deci_q;
    dbz_d   = dbz_q;
    busy_d  = (state_q == S_QUO) || (state_q == S_FRAC);
    done_d  = (state_q == S_FIN);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          rem_d   = '0;
          deci_d  = '0;
          dbz_d   = 1'b0;
          cnt_d   = CNT_W'(WIDTH - 1);
          step_d  = 2'd0;
          dig_d   = DIG_W'(FRAC_DIGITS - 1);
          digit_d = 4'd0;
          if (bus.b == '0) begin
            dbz_d   = 1'b1;
            q_d     = '1;
            state_d = S_FIN;
          end else begin
            q_d     = '0;
            state_d = S_QUO;
          end
        end
      end

      S_QUO: begin
        rem_d        = sub_res;
        q_d[cnt_q]   = sub_ge;
        if (cnt_q == '0) begin
          state_d = S_FRAC;
          step_d  = 2'd0;
          dig_d   = DIG_W'(FRAC_DIGITS - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_FRAC: begin
        // Each digit is a 4-step restoring divide of rem*10 by b, MSB first.
        rem_d            = sub_res;
        digit_d[bit_pos] = sub_ge;
        step_d           = step_q + 2'd1;
        if (step_q == 2'd3) begin
          deci_d  = (deci_q << 3) + (deci_q << 1) + WIDTH'(digit_fin);
          digit_d = 4'd0;
          if (dig_q == '0) begin
            state_d = S_FIN;
          end else begin
            dig_d = dig_q - 1'b1;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      dig_q   <= '0;
      digit_q <= '0;
      q_q     <= '0;
      deci_q  <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      dig_q   <= dig_d;
      digit_q <= digit_d;
      q_q     <= q_d;
      deci_q  <= deci_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.q           = q_q;
  assign bus.deci        = deci_q;

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_div_seq_ctrl : scoreboard bench for the sequential divider            |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_div_seq_ctrl;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   busy_cnt;

  typedef struct {
    logic [15:0] q;
    logic [15:0] deci;
    logic        dbz;
    int          start_edge;
    int          lat;
    int          busy_n;
  } exp_t;

  exp_t sb[$];

  div_seq_ctrl_if #(.WIDTH(16)) bus ();

  div_seq_ctrl #(
    .WIDTH       (16),
    .FRAC_DIGITS (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic [15:0] eq, input logic [15:0] ed,
                          input logic dz, input int se);
    exp_t e;
    e.q          = eq;
    e.deci       = ed;
    e.dbz        = dz;
    e.start_edge = se;
    e.lat        = dz ? 1 : 33;
    e.busy_n     = dz ? 0 : 32;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("q",           int'(bus.q),           int'(e.q));
          chk("deci",        int'(bus.deci),        int'(e.deci));
          chk("div_by_zero", int'(bus.div_by_zero), int'(e.dbz));
          chk("latency",     cyc - e.start_edge,    e.lat);
          chk("busy_cycles", busy_cnt,              e.busy_n);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_done(input int max);
    int got;
    got = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1;
        break;
      end
    end
    chk("done_seen", got, 1);
  endtask

  task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] eq, input logic [15:0] ed,
                       input logic dz);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    push_exp(eq, ed, dz, cyc + 1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(40);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy),        0);
    chk("rst_done", int'(bus.done),        0);
    chk("rst_dbz",  int'(bus.div_by_zero), 0);
    chk("rst_q",    int'(bus.q),           0);
    chk("rst_deci", int'(bus.deci),        0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'd22,    16'd7,     16'd3,     16'd1428, 1'b0);
    do_op(16'd1,     16'd3,     16'd0,     16'd3333, 1'b0);
    do_op(16'd7,     16'd2,     16'd3,     16'd5000, 1'b0);
    do_op(16'd65535, 16'd1,     16'd65535, 16'd0,    1'b0);
    do_op(16'd65535, 16'd65535, 16'd1,     16'd0,    1'b0);
    do_op(16'd1,     16'd65535, 16'd0,     16'd0,    1'b0);
    do_op(16'd0,     16'd9,     16'd0,     16'd0,    1'b0);
    do_op(16'd10,    16'd0,     16'hFFFF,  16'd0,    1'b1);
    do_op(16'd9,     16'd4,     16'd2,     16'd2500, 1'b0);

    // Second start mid-operation and operand changes must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'd100;
    bus.b     = 16'd7;
    push_exp(16'd14, 16'd2857, 1'b0, cyc + 1);
    @(negedge clk);
    bus.start = 1'b0;
    idle_cycles(8);
    bus.start = 1'b1;
    bus.a     = 16'd5;
    bus.b     = 16'd5;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 16'h1234;
    bus.b     = 16'h0003;
    wait_done(40);
    idle_cycles(40);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'd50000;
    bus.b     = 16'd3;
    push_exp(16'd16666, 16'd6666, 1'b0, cyc + 1);
    @(negedge clk);
    bus.start = 1'b0;
    idle_cycles(18);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_q",    int'(bus.q),    0);
    chk("abort_deci", int'(bus.deci), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);
    do_op(16'd50000, 16'd3, 16'd16666, 16'd6666, 1'b0);

    // Start held high: accepted every 34 cycles.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'd9;
    bus.b     = 16'd2;
    push_exp(16'd4, 16'd5000, 1'b0, cyc + 1);
    push_exp(16'd4, 16'd5000, 1'b0, cyc + 1 + 34);
    push_exp(16'd4, 16'd5000, 1'b0, cyc + 1 + 68);
    idle_cycles(100);
    bus.start = 1'b0;
    begin
      int left;
      left = 1;
      for (int i = 0; i < 120; i++) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          left = 0;
          break;
        end
      end
      chk("drain", left, 0);
    end
    idle_cycles(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for the 16-bit unsigned divide operation.
- Produces the integer quotient and a 4-digit truncated decimal fraction. The fraction is a binary value 0..9999, e.g. 1/3 -> 3333.
- Replaces the single-cycle combinational divider with one shared subtract/compare datapath stepped by an FSM, with a start/busy/done handshake.
- Sits between the calculator operation decoder and the result/display register.

Parameters:
- WIDTH, 16, operand and quotient width.
- FRAC_DIGITS, 4, number of decimal fraction digits generated.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- a  input  16  dividend, unsigned; sampled on the accepted start edge.
- b  input  16  divisor, unsigned; sampled on the accepted start edge.
- busy  output  1  high while an operation is in progress (QUO, FRAC).
- done  output  1  one-cycle pulse; q, deci and div_by_zero are valid from this cycle.
- div_by_zero  output  1  set when the latched b was 0; held with the results.
- q  output  16  integer quotient, floor(a/b).
- deci  output  16  floor(10^4 * (a mod b) / b), range 0..9999.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: busy=0, done=0, div_by_zero=0, q=0, deci=0. FSM=IDLE. Internal remainder, counters and operand registers are cleared.
- Reset mid-operation aborts immediately. No done pulse; outputs return to their reset values.
- States are IDLE, QUO, FRAC, FIN.
- IDLE:
  - On start=1, latch a and b, clear remainder and deci, clear div_by_zero.
  - If b==0: go to FIN with div_by_zero=1, q=16'hFFFF, deci=0.
  - Otherwise go to QUO with bit counter = 15.
- QUO: restoring division, one quotient bit per cycle, MSB first.
  - rem' = {rem, a[i]}, 17-bit.
  - If rem' >= b, subtract b and set q[i]=1; else q[i]=0.
  - 16 cycles, then go to FRAC with digit counter = FRAC_DIGITS-1.
- FRAC: per digit, 4 cycles.
  - Cycle 0: R = rem*10, 20-bit; the product is < 10*b, so the digit is < 10.
  - Cycles 0..3: 4-bit restoring divide of R by b, producing digit d (0..9) and the new rem.
  - After the 4th cycle: deci <= deci*10 + d. The 16-bit arithmetic cannot overflow because deci ≤ 9999.
  - After FRAC_DIGITS digits (16 cycles), go to FIN.
- FIN: done=1 for exactly one cycle, busy=0, then go to IDLE.
- Output holding: q, deci and div_by_zero hold until the next accepted start. q and deci may show partial values while busy=1; the consumer uses them only on or after done.
- Latency, with the start edge counted as edge 0:
  - Normal operation: done is high in the cycle after edge 33 (33 clocks); busy is high for cycles 1..32.
  - b==0: done is high after edge 1.
- start while busy or in FIN is ignored; it is not queued.
- start held high continuously back-to-back: a new operation is accepted in the IDLE cycle following FIN.
- Operand changes after the accepted start edge have no effect.
- Boundary cases:
  - a=0 gives q=0, deci=0, with full latency.
  - b=1 gives rem always 0, so deci=0.
  - a<b gives q=0.

Test Plan:
- Reset, then start with a=22, b=7 -> done exactly 33 clocks after the start edge; q=3, deci=1428, div_by_zero=0; busy high for 32 cycles.
- a=1, b=3 -> q=0, deci=3333. a=7, b=2 -> q=3, deci=5000. a=65535, b=1 -> q=65535, deci=0. a=65535, b=65535 -> q=1, deci=0. a=1, b=65535 -> q=0, deci=0.
- a=10, b=0 -> done 1 clock after start; div_by_zero=1, q=16'hFFFF, deci=0. A following a=9, b=4 clears the flag -> q=2, deci=2500.
- Start with a=100, b=7. Pulse start with a=5, b=5 at cycle 10 and change a/b mid-operation -> second start ignored; q=14, deci=2857; single done pulse.
- Start with a=50000, b=3. Assert rst_n=0 at cycle 20 -> busy, done, q and deci go to 0 asynchronously; no done pulse. After release, a=50000, b=3 -> q=16666, deci=6666.
- start held high for 100 cycles with a=9, b=2 -> done pulses at cycle 33 and again 34 cycles later; q=4, deci=5000 each time.
